// File: rtl/cpu_run_monitor.sv
// Run controller for the CPU core: sequences cpu_reset, runs for a bounded
// number of cycles, folds result into a rotate-XOR signature and grades it.
module cpu_run_monitor #(
  parameter int                  DATA_W        = 16,
  parameter int                  RST_CYCLES    = 3,
  parameter int                  MAX_CYCLES    = 25,
  parameter int                  STABLE_CYCLES = 4,
  parameter logic [DATA_W-1:0]   EXP_SIG       = 16'h0033,
  localparam int                 CNT_W         = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] result,
  output logic              cpu_reset,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] signature,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic              pass
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cc_q, cc_d, cc_upd;
  logic [DATA_W-1:0] sig_q, sig_d, sig_upd;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [STAB_W-1:0] stab_q, stab_d, stab_upd;
  logic              cpu_reset_q, cpu_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;
  logic              clear_run;

  // start is a level, sampled only in IDLE and DONE; there is no handshake
  // back to the source, so holding it high simply re-arms after each run.
  always_comb begin
    cc_upd  = cc_q + CNT_W'(1);
    sig_upd = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ result;
    if (stab_q == '0 || result != prev_q)
      stab_upd = STAB_W'(1);
    else if (stab_q == STAB_W'(STABLE_CYCLES))
      stab_upd = stab_q;
    else
      stab_upd = stab_q + STAB_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cc_d        = cc_q;
    sig_d       = sig_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    cpu_reset_d = cpu_reset_q;
    running_d   = running_q;
    done_d      = done_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    clear_run   = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_reset_d = 1'b1;
        if (start) begin
          state_d   = RST_HOLD;
          hold_d    = HOLD_W'(RST_CYCLES);
          clear_run = 1'b1;
        end
      end
      RST_HOLD: begin
        cpu_reset_d = 1'b1;
        clear_run   = 1'b1;
        hold_d      = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          state_d     = RUN;
          cpu_reset_d = 1'b0;
          running_d   = 1'b1;
        end
      end
      RUN: begin
        cc_d   = cc_upd;
        sig_d  = sig_upd;
        stab_d = stab_upd;
        prev_d = result;
        // Halt is tested first so a coincident budget expiry reports as halt.
        if (stab_upd == STAB_W'(STABLE_CYCLES)) begin
          state_d     = DONE;
          halted_d    = 1'b1;
          pass_d      = (sig_upd == EXP_SIG);
          done_d      = 1'b1;
          running_d   = 1'b0;
          cpu_reset_d = 1'b1;
        end else if (cc_upd == CNT_W'(MAX_CYCLES)) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          done_d      = 1'b1;
          running_d   = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      DONE: begin
        cpu_reset_d = 1'b1;
        if (start) begin
          state_d   = RST_HOLD;
          hold_d    = HOLD_W'(RST_CYCLES);
          clear_run = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cpu_reset_d = 1'b1;
      end
    endcase

    if (clear_run) begin
      cc_d      = '0;
      sig_d     = '0;
      prev_d    = '0;
      stab_d    = '0;
      done_d    = 1'b0;
      halted_d  = 1'b0;
      timeout_d = 1'b0;
      pass_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cc_q        <= '0;
      sig_q       <= '0;
      prev_q      <= '0;
      stab_q      <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cc_q        <= cc_d;
      sig_q       <= sig_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign cycle_count = cc_q;
  assign signature   = sig_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: default instance plus a MAX_CYCLES=4 instance
// sharing the same stimulus, so halt/timeout coincidence is seen alongside.
module tb_cpu_run_monitor;

  localparam int DW  = 16;
  localparam int CW  = 5;
  localparam int CW2 = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] result;

  logic          cpu_reset, running, done, halted, timeout, pass;
  logic [CW-1:0] cycle_count;
  logic [DW-1:0] signature;

  logic           cpu_reset_b, running_b, done_b, halted_b, timeout_b, pass_b;
  logic [CW2-1:0] cycle_count_b;
  logic [DW-1:0]  signature_b;

  cpu_run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .result(result),
    .cpu_reset(cpu_reset), .running(running), .cycle_count(cycle_count),
    .signature(signature), .done(done), .halted(halted),
    .timeout(timeout), .pass(pass)
  );

  cpu_run_monitor #(.MAX_CYCLES(4), .STABLE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .result(result),
    .cpu_reset(cpu_reset_b), .running(running_b), .cycle_count(cycle_count_b),
    .signature(signature_b), .done(done_b), .halted(halted_b),
    .timeout(timeout_b), .pass(pass_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            alt;      // 1: a on odd RUN edges, b on even
    int            sw;       // else: a for edges 1..sw, b afterwards
    int            exp_cc;
    bit            exp_halt;
    bit            exp_to;
    bit            exp_pass;
    logic [DW-1:0] exp_sig;
    bit            exp2_halt;
    bit            exp2_to;
  } vec_t;

  vec_t vecs[4];

  logic [CW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input vec_t v, input int k);
    if (v.alt) return (k % 2 == 1) ? v.a : v.b;
    return (k <= v.sw) ? v.a : v.b;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_running"}, running, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_signature"}, signature, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_b_cpu_reset"}, cpu_reset_b, 1);
    check({tag, "_b_done"}, done_b, 0);
  endtask

  // Leaves the bench at the negedge after the first RUN-entry edge.
  task automatic start_and_hold();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("hold0_cpu_reset", cpu_reset, 1);
    @(negedge clk);
    check("hold1_cpu_reset", cpu_reset, 1);
    check("hold1_done_clr", done, 0);
    check("hold1_halted_clr", halted, 0);
    check("hold1_timeout_clr", timeout, 0);
    check("hold1_cc_clr", cycle_count, 0);
    check("hold1_sig_clr", signature, 0);
    check("hold1_running", running, 0);
    @(negedge clk);
    check("hold2_cpu_reset", cpu_reset, 1);
    @(negedge clk);
    check("run_cpu_reset", cpu_reset, 0);
    check("run_running", running, 1);
    check("run_b_running", running_b, 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [DW-1:0]    m;
    logic [CW+DW-1:0] e;
    bit               fin;
    m = '0;
    fin = 1'b0;
    result = pat(v, 1);
    start_and_hold();
    for (int k = 1; k <= 40 && !fin; k++) begin
      m = {m[DW-2:0], m[DW-1]} ^ result;
      exp_q.push_back({CW'(k), m});
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_sig_k%0d", idx, k), signature, e[DW-1:0]);
      check($sformatf("v%0d_cc_k%0d", idx, k), cycle_count, e[CW+DW-1:DW]);
      if (done) fin = 1'b1;
      else result = pat(v, k + 1);
    end
    check($sformatf("v%0d_done", idx), done, 1);
    check($sformatf("v%0d_final_cc", idx), cycle_count, v.exp_cc);
    check($sformatf("v%0d_final_sig", idx), signature, v.exp_sig);
    check($sformatf("v%0d_halted", idx), halted, v.exp_halt);
    check($sformatf("v%0d_timeout", idx), timeout, v.exp_to);
    check($sformatf("v%0d_pass", idx), pass, v.exp_pass);
    check($sformatf("v%0d_cpu_reset", idx), cpu_reset, 1);
    check($sformatf("v%0d_running", idx), running, 0);
    check($sformatf("v%0d_b_done", idx), done_b, 1);
    check($sformatf("v%0d_b_halted", idx), halted_b, v.exp2_halt);
    check($sformatf("v%0d_b_timeout", idx), timeout_b, v.exp2_to);
    result = 16'hFFFF;
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_hold_sig", idx), signature, v.exp_sig);
    check($sformatf("v%0d_hold_done", idx), done, 1);
    check($sformatf("v%0d_hold_cc", idx), cycle_count, v.exp_cc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0005, 16'h0005, 1'b0, 100,  4, 1'b1, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b0};
    vecs[1] = '{16'h0001, 16'h0002, 1'b1,   0, 25, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[2] = '{16'h0006, 16'h0006, 1'b0, 100,  4, 1'b1, 1'b0, 1'b0, 16'h0022, 1'b1, 1'b0};
    vecs[3] = '{16'h0007, 16'h0000, 1'b0,   2,  6, 1'b1, 1'b0, 1'b0, 16'h0090, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    result = '0;
    #1;
    check_reset_vals("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_autostart_running", running, 0);
    check("idle_cpu_reset", cpu_reset, 1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of a run.
    result = 16'h1234;
    start_and_hold();
    repeat (2) @(negedge clk);
    check("midrun_cc", cycle_count, 2);
    check("midrun_running", running, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrun_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_running", running, 0);
    check("post_rst_cpu_reset", cpu_reset, 1);
    check("post_rst_done", done, 0);

    run_vec(vecs[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
